// File: rtl/mips_mux_pkg.sv
// Shared select encodings for the MIPS datapath multiplexers.
// Select codes are binary, not one-hot.
package mips_mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_0 = 2'd0;
    localparam sel_t SEL_1 = 2'd1;
    localparam sel_t SEL_2 = 2'd2;
    localparam sel_t SEL_3 = 2'd3;

endpackage : mips_mux_pkg

// File: rtl/mux4to1_if.sv
// Data/select bundle for a 4-input datapath multiplexer.
// The slave side is the mux; the master side drives the candidates and select.
interface mux4to1_if #(
    parameter int unsigned size = 32
);
    import mips_mux_pkg::*;

    logic [size-1:0] data0_i;
    logic [size-1:0] data1_i;
    logic [size-1:0] data2_i;
    logic [size-1:0] data3_i;
    sel_t            select_i;
    logic [size-1:0] data_o;
    logic [size-1:0] data_q_o;
    sel_t            select_q_o;

    modport master (
        output data0_i, data1_i, data2_i, data3_i, select_i,
        input  data_o, data_q_o, select_q_o
    );

    modport slave (
        input  data0_i, data1_i, data2_i, data3_i, select_i,
        output data_o, data_q_o, select_q_o
    );

endinterface : mux4to1_if

// File: rtl/mux4to1_core.sv
// Purely combinational 4:1 selector, bit-exact and reset-independent.
module mux4to1_core
    import mips_mux_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic [size-1:0] data0_i,
    input  logic [size-1:0] data1_i,
    input  logic [size-1:0] data2_i,
    input  logic [size-1:0] data3_i,
    input  sel_t            select_i,
    output logic [size-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (select_i)
            SEL_0:   data_o = data0_i;
            SEL_1:   data_o = data1_i;
            SEL_2:   data_o = data2_i;
            // Code 3 is the default arm; an unknown select propagates X in simulation only.
            default: data_o = ((^select_i) === 1'bx) ? {size{1'bx}} : data3_i;
        endcase
    end

endmodule : mux4to1_core

// File: rtl/mux4to1.sv
// 4:1 datapath mux with a combinational output plus a registered copy of
// the result and select for pipeline-stage consumers.
module mux4to1
    import mips_mux_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mux4to1_if.slave    bus
);

    logic [size-1:0] data_d;
    logic [size-1:0] data_q;
    sel_t            select_d;
    sel_t            select_q;

    mux4to1_core #(
        .size (size)
    ) u_core (
        .data0_i  (bus.data0_i),
        .data1_i  (bus.data1_i),
        .data2_i  (bus.data2_i),
        .data3_i  (bus.data3_i),
        .select_i (bus.select_i),
        .data_o   (data_d)
    );

    assign select_d = bus.select_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q   <= '0;
            select_q <= SEL_0;
        end else begin
            data_q   <= data_d;
            select_q <= select_d;
        end
    end

    assign bus.data_o     = data_d;
    assign bus.data_q_o   = data_q;
    assign bus.select_q_o = select_q;

endmodule : mux4to1

// File: tb/tb_mux4to1.sv
// Self-checking bench for mux4to1 at size=15: directed vectors, async reset
// behaviour and a randomized sweep against an array-indexed reference.
module tb_mux4to1;

    localparam int unsigned W = 15;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mux4to1_if #(.size(W)) bus ();

    mux4to1 #(.size(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the selected candidate is simply the select-th element.
    function automatic logic [W-1:0] model(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                           input logic [W-1:0] d2, input logic [W-1:0] d3,
                                           input int sel);
        logic [W-1:0] cand [4];
        cand[0] = d0; cand[1] = d1; cand[2] = d2; cand[3] = d3;
        return cand[sel];
    endfunction

    task automatic drive(input int d0, input int d1, input int d2, input int d3, input int sel);
        bus.data0_i  = W'(d0);
        bus.data1_i  = W'(d1);
        bus.data2_i  = W'(d2);
        bus.data3_i  = W'(d3);
        bus.select_i = 2'(sel);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(5, 6, 7, 8, 2);
        #1;
        tests++;
        if (bus.data_q_o !== '0) begin
            fails++; $display("FAIL reset_data_q got=%0d exp=0", bus.data_q_o);
        end
        tests++;
        if (bus.select_q_o !== 2'd0) begin
            fails++; $display("FAIL reset_select_q got=%0d exp=0", bus.select_q_o);
        end
        tests++;
        if (bus.data_o !== W'(7)) begin
            fails++; $display("FAIL reset_data_o_valid got=%0d exp=7", bus.data_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed(input string name, input int d0, input int d1, input int d2,
                                 input int d3, input int sel, input int exp);
        @(negedge clk);
        drive(d0, d1, d2, d3, sel);
        #1;
        tests++;
        if (bus.data_o !== W'(exp)) begin
            fails++; $display("FAIL %s_comb got=%0d exp=%0d", name, bus.data_o, exp);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.data_q_o !== W'(exp)) begin
            fails++; $display("FAIL %s_data_q got=%0d exp=%0d", name, bus.data_q_o, exp);
        end
        tests++;
        if (bus.select_q_o !== 2'(sel)) begin
            fails++; $display("FAIL %s_select_q got=%0d exp=%0d", name, bus.select_q_o, sel);
        end
    endtask

    task automatic test_async_reset();
        // Registers hold 144/3 from the previous vector.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.data_q_o !== '0) begin
            fails++; $display("FAIL async_rst_data_q got=%0d exp=0", bus.data_q_o);
        end
        tests++;
        if (bus.select_q_o !== 2'd0) begin
            fails++; $display("FAIL async_rst_select_q got=%0d exp=0", bus.select_q_o);
        end
        tests++;
        if (bus.data_o !== W'(144)) begin
            fails++; $display("FAIL async_rst_data_o got=%0d exp=144", bus.data_o);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.data_q_o !== '0 || bus.data_o !== W'(144)) begin
            fails++; $display("FAIL rst_hold got_q=%0d got_o=%0d exp_q=0 exp_o=144",
                              bus.data_q_o, bus.data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (bus.data_q_o !== W'(144) || bus.select_q_o !== 2'd3) begin
            fails++; $display("FAIL rst_release got_q=%0d got_sel=%0d exp_q=144 exp_sel=3",
                              bus.data_q_o, bus.select_q_o);
        end
    endtask

    task automatic test_back_to_back(input int cycles);
        logic [W-1:0] d [4];
        logic [W-1:0] exp;
        logic [W-1:0] prev_exp;
        int           sel;
        int           prev_sel;
        int           seen [4];
        seen = '{0, 0, 0, 0};
        prev_exp = '0;
        prev_sel = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            foreach (d[k]) d[k] = W'($urandom);
            sel = int'($urandom_range(3, 0));
            seen[sel]++;
            drive(int'(d[0]), int'(d[1]), int'(d[2]), int'(d[3]), sel);
            exp = model(d[0], d[1], d[2], d[3], sel);
            #1;
            tests++;
            if (bus.data_o !== exp) begin
                fails++; $display("FAIL sweep_comb cyc=%0d got=%0d exp=%0d", c, bus.data_o, exp);
            end
            if (c > 0) begin
                // Before the edge, the registers still show the previous cycle's result.
                tests++;
                if (bus.data_q_o !== prev_exp || bus.select_q_o !== 2'(prev_sel)) begin
                    fails++; $display("FAIL sweep_pre_edge cyc=%0d got_q=%0d got_sel=%0d exp_q=%0d exp_sel=%0d",
                                      c, bus.data_q_o, bus.select_q_o, prev_exp, prev_sel);
                end
            end
            @(posedge clk);
            #1;
            tests++;
            if (bus.data_q_o !== exp || bus.select_q_o !== 2'(sel)) begin
                fails++; $display("FAIL sweep_reg cyc=%0d got_q=%0d got_sel=%0d exp_q=%0d exp_sel=%0d",
                                  c, bus.data_q_o, bus.select_q_o, exp, sel);
            end
            prev_exp = exp;
            prev_sel = sel;
        end
        tests++;
        if (seen[0] == 0 || seen[1] == 0 || seen[2] == 0 || seen[3] == 0) begin
            fails++; $display("FAIL sweep_coverage got=%0d/%0d/%0d/%0d exp=all_nonzero",
                              seen[0], seen[1], seen[2], seen[3]);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_directed("sel1", 39, 53, 17, 26, 1, 53);
        test_directed("sel0", 37, 17, 53, 39, 0, 37);
        test_directed("sel2", 19, 53, 17, 26, 2, 17);
        test_directed("sel3", 143, 120, 123, 144, 3, 144);
        test_async_reset();
        test_back_to_back(1000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mux4to1
